// File: rtl/axi4_pkg.sv
// Shared definitions for the single-outstanding AXI4 burst master: FSM states,
// response codes and the 4KB page limit.
package axi4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [11:0] BOUNDARY_4KB = 12'hFFF;

endpackage

// File: rtl/axi4_burst_master_if.sv
// Command port plus the five AXI4 channels of the burst master, bundled so the
// master and its slave/bench see one consistent set of signals.
interface axi4_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic [2:0]            cmd_size;
    logic [DATA_WIDTH-1:0] cmd_seed;
    logic                  done;
    logic                  err;
    logic                  mismatch;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size, cmd_seed,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output cmd_ready, done, err, mismatch,
        output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
        output ARADDR, ARLEN, ARSIZE, ARVALID, RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size, cmd_seed,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  cmd_ready, done, err, mismatch,
        input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARVALID, RREADY
    );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst master: writes a seed+beat pattern or reads
// it back and checks it, reporting err/mismatch with a one-cycle done pulse.
module axi4_burst_master
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input logic                 ACLK,
    input logic                 ARESET,
    axi4_burst_master_if.master bus
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [7:0]            r_beat;
    logic                  r_err;
    logic                  r_mismatch;

    logic [DATA_WIDTH-1:0] w_pattern;
    logic                  w_last_beat;
    logic [31:0]           w_bytes;
    logic [31:0]           w_span;
    logic                  w_reject;

    assign w_pattern   = r_seed + DATA_WIDTH'(r_beat);
    assign w_last_beat = (r_beat == r_len);
    assign w_bytes     = 32'd1 << r_size;
    // Span is measured as len<<size from the start offset inside the 4KB page.
    assign w_span      = 32'(r_addr[11:0]) + (32'(r_len) << r_size);
    assign w_reject    = (w_span > 32'(BOUNDARY_4KB))
                      || (w_bytes > 32'(DATA_WIDTH / 8))
                      || ((32'(r_addr) & (w_bytes - 32'd1)) != 32'd0);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.cmd_ready = (r_state == ST_IDLE);
        bus.AWVALID   = (r_state == ST_AW);
        bus.WVALID    = (r_state == ST_W);
        bus.WLAST     = (r_state == ST_W) && w_last_beat;
        bus.BREADY    = (r_state == ST_B);
        bus.ARVALID   = (r_state == ST_AR);
        bus.RREADY    = (r_state == ST_R);
        bus.done      = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE:  if (bus.cmd_valid) w_next = ST_CHECK;
            ST_CHECK: begin
                if (w_reject)     w_next = ST_DONE;
                else if (r_write) w_next = ST_AW;
                else              w_next = ST_AR;
            end
            ST_AW:    if (bus.AWREADY) w_next = ST_W;
            ST_W:     if (bus.WREADY && w_last_beat) w_next = ST_B;
            ST_B:     if (bus.BVALID) w_next = ST_DONE;
            ST_AR:    if (bus.ARREADY) w_next = ST_R;
            // The read burst ends on our own beat count even if RLAST disagrees.
            ST_R:     if (bus.RVALID && w_last_beat) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_seed     <= '0;
            r_beat     <= '0;
            r_err      <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_write    <= bus.cmd_write;
                        r_addr     <= bus.cmd_addr;
                        r_len      <= bus.cmd_len;
                        r_size     <= bus.cmd_size;
                        r_seed     <= bus.cmd_seed;
                        r_beat     <= '0;
                        r_err      <= 1'b0;
                        r_mismatch <= 1'b0;
                    end
                end
                ST_CHECK: if (w_reject) r_err <= 1'b1;
                ST_W:     if (bus.WREADY) r_beat <= r_beat + 8'd1;
                ST_B:     if (bus.BVALID) r_err <= (bus.BRESP != RESP_OKAY);
                ST_R: begin
                    if (bus.RVALID) begin
                        if (bus.RDATA != w_pattern) r_mismatch <= 1'b1;
                        if ((bus.RRESP != RESP_OKAY) || (bus.RLAST != w_last_beat))
                            r_err <= 1'b1;
                        r_beat <= r_beat + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One burst address per transaction; the slave does the INCR stepping.
    assign bus.AWADDR   = r_addr;
    assign bus.AWLEN    = r_len;
    assign bus.AWSIZE   = r_size;
    assign bus.ARADDR   = r_addr;
    assign bus.ARLEN    = r_len;
    assign bus.ARSIZE   = r_size;
    assign bus.WDATA    = w_pattern;
    assign bus.err      = r_err;
    assign bus.mismatch = r_mismatch;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Scoreboard bench for axi4_burst_master: directed commands push expected
// AW/AR/W/done records; a negedge monitor pops and compares them.
module tb_axi4_burst_master;
    import axi4_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axi4_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [26:0] q_aw[$];
    logic [26:0] q_ar[$];
    logic [32:0] q_w[$];
    logic [1:0]  q_done[$];

    int         cfg_aw_stall    = 0;
    int         cfg_w_stall     = 0;
    bit         cfg_w_rand      = 0;
    logic [1:0] cfg_bresp       = RESP_OKAY;
    int         cfg_corrupt     = -1;
    int         cfg_rerr_beat   = -1;
    bit         cfg_rlast_early = 0;

    logic [31:0] mem [int];
    int rd_base, rd_beat, rd_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Write-side slave: counted AWREADY/WREADY stalls, memory capture, B response.
    initial begin
        bit aw_hs, w_hs, b_hs, w_last;
        logic [15:0] a;
        logic [31:0] d;
        int aw_cnt, w_cnt, wbeat, wbase;
        aw_cnt = 0; w_cnt = 0; wbeat = 0; wbase = 0;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        bus.BRESP   = RESP_OKAY;
        forever begin
            @(negedge ACLK);
            aw_hs  = bus.AWVALID && bus.AWREADY;
            a      = bus.AWADDR;
            w_hs   = bus.WVALID && bus.WREADY;
            w_last = bus.WLAST;
            d      = bus.WDATA;
            b_hs   = bus.BVALID && bus.BREADY;
            if (bus.AWVALID && !bus.AWREADY) aw_cnt++;
            if (bus.WVALID && !bus.WREADY) w_cnt++;
            @(posedge ACLK);
            #1;
            if (ARESET) begin
                bus.BVALID = 1'b0;
                aw_cnt = 0;
                w_cnt  = 0;
            end else begin
                if (aw_hs) begin
                    wbase = int'(a) >> 2;
                    wbeat = 0;
                    aw_cnt = 0;
                    w_cnt  = 0;
                end
                if (w_hs) begin
                    mem[wbase + wbeat] = d;
                    wbeat++;
                    if (w_last) begin
                        bus.BVALID = 1'b1;
                        bus.BRESP  = cfg_bresp;
                    end
                end
                if (b_hs) bus.BVALID = 1'b0;
            end
            bus.AWREADY = (aw_cnt >= cfg_aw_stall);
            bus.WREADY  = (w_cnt >= cfg_w_stall) && (!cfg_w_rand || ($urandom_range(0, 3) != 0));
        end
    end

    // Read-side slave: INCR read from the memory model with optional fault injection.
    initial begin
        bit ar_hs, r_hs, pres;
        logic [15:0] a;
        logic [7:0]  l;
        logic [31:0] d;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RDATA   = '0;
        bus.RRESP   = RESP_OKAY;
        bus.RLAST   = 1'b0;
        forever begin
            @(negedge ACLK);
            ar_hs = bus.ARVALID && bus.ARREADY;
            a     = bus.ARADDR;
            l     = bus.ARLEN;
            r_hs  = bus.RVALID && bus.RREADY;
            @(posedge ACLK);
            #1;
            bus.ARREADY = 1'b1;
            pres = 0;
            if (ARESET) bus.RVALID = 1'b0;
            else if (ar_hs) begin
                rd_base = int'(a) >> 2;
                rd_len  = int'(l);
                rd_beat = 0;
                pres    = 1;
            end else if (r_hs) begin
                if (rd_beat == rd_len) bus.RVALID = 1'b0;
                else begin
                    rd_beat++;
                    pres = 1;
                end
            end
            if (pres) begin
                d = mem.exists(rd_base + rd_beat) ? mem[rd_base + rd_beat] : 32'h0;
                if (rd_beat == cfg_corrupt) d = d ^ 32'd1;
                bus.RVALID = 1'b1;
                bus.RDATA  = d;
                bus.RRESP  = (rd_beat == cfg_rerr_beat) ? RESP_SLVERR : RESP_OKAY;
                bus.RLAST  = cfg_rlast_early ? (rd_beat == 0) : (rd_beat == rd_len);
            end
        end
    end

    // Monitor: pops expected records on handshakes and checks stall stability.
    initial begin
        logic prev_aw_st, prev_w_st, prev_done;
        logic [26:0] aw_f;
        logic [32:0] w_f;
        prev_aw_st = 0; prev_w_st = 0; prev_done = 0;
        aw_f = '0; w_f = '0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                prev_aw_st = 0;
                prev_w_st  = 0;
                prev_done  = 0;
            end else begin
                if (prev_aw_st)
                    chk("aw_stable", 64'({bus.AWVALID, bus.AWADDR, bus.AWLEN, bus.AWSIZE}), 64'({1'b1, aw_f}));
                if (prev_w_st)
                    chk("w_stable", 64'({bus.WVALID, bus.WDATA, bus.WLAST}), 64'({1'b1, w_f}));
                if (bus.AWVALID && bus.AWREADY) begin
                    chk("aw_expected", 64'(q_aw.size() != 0), 64'd1);
                    if (q_aw.size() != 0)
                        chk("aw_fields", 64'({bus.AWADDR, bus.AWLEN, bus.AWSIZE}), 64'(q_aw.pop_front()));
                end
                if (bus.ARVALID && bus.ARREADY) begin
                    chk("ar_expected", 64'(q_ar.size() != 0), 64'd1);
                    if (q_ar.size() != 0)
                        chk("ar_fields", 64'({bus.ARADDR, bus.ARLEN, bus.ARSIZE}), 64'(q_ar.pop_front()));
                end
                if (bus.WVALID && bus.WREADY) begin
                    chk("w_expected", 64'(q_w.size() != 0), 64'd1);
                    if (q_w.size() != 0)
                        chk("w_beat", 64'({bus.WDATA, bus.WLAST}), 64'(q_w.pop_front()));
                end
                if (bus.done) begin
                    chk("done_one_cycle", 64'(prev_done), 64'd0);
                    chk("done_expected", 64'(q_done.size() != 0), 64'd1);
                    if (q_done.size() != 0)
                        chk("done_err_mismatch", 64'({bus.err, bus.mismatch}), 64'(q_done.pop_front()));
                end
                prev_aw_st = bus.AWVALID && !bus.AWREADY;
                aw_f       = {bus.AWADDR, bus.AWLEN, bus.AWSIZE};
                prev_w_st  = bus.WVALID && !bus.WREADY;
                w_f        = {bus.WDATA, bus.WLAST};
                prev_done  = bus.done;
            end
        end
    end

    task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [31:0] sd);
        int t;
        t = 0;
        @(negedge ACLK);
        while (!bus.cmd_ready && t < 100) begin
            @(negedge ACLK);
            t++;
        end
        chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_size  = s;
        bus.cmd_seed  = sd;
        bus.cmd_valid = 1'b1;
        @(posedge ACLK);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t;
        t = 0;
        while (t < budget) begin
            @(negedge ACLK);
            if (bus.done) break;
            t++;
        end
        chk({name, "_done_seen"}, 64'(bus.done), 64'd1);
    endtask

    task automatic reject_case(input string name, input logic [15:0] a, input logic [7:0] l,
                               input logic [2:0] s);
        q_done.push_back(2'b10);
        issue(1'b1, a, l, s, 32'h0);
        wait_done(name, 3);
    endtask

    initial begin
        int t;
        bit seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_size  = '0;
        bus.cmd_seed  = '0;

        repeat (3) @(negedge ACLK);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_ctrl_zero", 64'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY,
                                  bus.WLAST, bus.done, bus.err, bus.mismatch}), 64'd0);
        chk("rst_addr_data_zero", 64'({bus.AWADDR, bus.ARADDR, bus.WDATA}), 64'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        // Basic 4-beat write
        q_aw.push_back({16'h0010, 8'd3, 3'd2});
        q_w.push_back({32'h0000_0100, 1'b0});
        q_w.push_back({32'h0000_0101, 1'b0});
        q_w.push_back({32'h0000_0102, 1'b0});
        q_w.push_back({32'h0000_0103, 1'b1});
        q_done.push_back(2'b00);
        issue(1'b1, 16'h0010, 8'd3, 3'd2, 32'h100);
        wait_done("wr_basic", 50);

        // Read back clean, then with beat 2 corrupted
        q_ar.push_back({16'h0010, 8'd3, 3'd2});
        q_done.push_back(2'b00);
        issue(1'b0, 16'h0010, 8'd3, 3'd2, 32'h100);
        wait_done("rd_clean", 50);

        cfg_corrupt = 2;
        q_ar.push_back({16'h0010, 8'd3, 3'd2});
        q_done.push_back(2'b01);
        issue(1'b0, 16'h0010, 8'd3, 3'd2, 32'h100);
        wait_done("rd_corrupt", 50);
        cfg_corrupt = -1;

        // Rejections: 4KB cross, exact-page overflow, oversize, misaligned
        reject_case("rej_4kb", 16'h0FF0, 8'd7, 3'd2);
        reject_case("rej_4kb_edge", 16'h0FF4, 8'd3, 3'd2);
        reject_case("rej_size", 16'h0020, 8'd0, 3'd3);
        reject_case("rej_align", 16'h0012, 8'd0, 3'd2);

        // Just inside the page (0xFF0 + 3<<2 = 0xFFC) is accepted
        q_aw.push_back({16'h0FF0, 8'd3, 3'd2});
        q_w.push_back({32'h7000_0000, 1'b0});
        q_w.push_back({32'h7000_0001, 1'b0});
        q_w.push_back({32'h7000_0002, 1'b0});
        q_w.push_back({32'h7000_0003, 1'b1});
        q_done.push_back(2'b00);
        issue(1'b1, 16'h0FF0, 8'd3, 3'd2, 32'h7000_0000);
        wait_done("wr_page_edge", 50);

        // Byte-size single beat on odd address
        q_aw.push_back({16'h0033, 8'd0, 3'd0});
        q_w.push_back({32'h0000_00AA, 1'b1});
        q_done.push_back(2'b00);
        issue(1'b1, 16'h0033, 8'd0, 3'd0, 32'hAA);
        wait_done("wr_byte", 50);

        // 256-beat write with stalls; pattern wraps through zero
        cfg_aw_stall = 5;
        cfg_w_stall  = 5;
        cfg_w_rand   = 1;
        q_aw.push_back({16'h0100, 8'd255, 3'd2});
        for (int i = 0; i < 256; i++)
            q_w.push_back({32'hFFFF_FF80 + 32'(i), (i == 255)});
        q_done.push_back(2'b00);
        issue(1'b1, 16'h0100, 8'd255, 3'd2, 32'hFFFF_FF80);
        wait_done("wr_long", 3000);
        cfg_aw_stall = 0;
        cfg_w_stall  = 0;
        cfg_w_rand   = 0;

        // BRESP SLVERR
        cfg_bresp = RESP_SLVERR;
        q_aw.push_back({16'h0040, 8'd1, 3'd2});
        q_w.push_back({32'h0000_0055, 1'b0});
        q_w.push_back({32'h0000_0056, 1'b1});
        q_done.push_back(2'b10);
        issue(1'b1, 16'h0040, 8'd1, 3'd2, 32'h55);
        wait_done("wr_slverr", 50);
        cfg_bresp = RESP_OKAY;

        // RRESP SLVERR on beat 1
        cfg_rerr_beat = 1;
        q_ar.push_back({16'h0010, 8'd3, 3'd2});
        q_done.push_back(2'b10);
        issue(1'b0, 16'h0010, 8'd3, 3'd2, 32'h100);
        wait_done("rd_slverr", 50);
        cfg_rerr_beat = -1;

        // RLAST early on beat 0 of a 2-beat read
        cfg_rlast_early = 1;
        q_ar.push_back({16'h0010, 8'd1, 3'd2});
        q_done.push_back(2'b10);
        issue(1'b0, 16'h0010, 8'd1, 3'd2, 32'h100);
        wait_done("rd_rlast_early", 50);
        cfg_rlast_early = 0;

        // Reset while beat 2 is presented: no more beats, no done
        q_aw.push_back({16'h0080, 8'd5, 3'd2});
        q_w.push_back({32'h0000_0200, 1'b0});
        q_w.push_back({32'h0000_0201, 1'b0});
        issue(1'b1, 16'h0080, 8'd5, 3'd2, 32'h200);
        seen = 0;
        t = 0;
        while (!seen && t < 50) begin
            @(negedge ACLK);
            seen = bus.WVALID && bus.WREADY && (bus.WDATA == 32'h201);
            t++;
        end
        chk("rst_mid_beat1_seen", 64'(seen), 64'd1);
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        #1;
        chk("rst_mid_wvalid", 64'(bus.WVALID), 64'd0);
        chk("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_mid_wdata", 64'(bus.WDATA), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("rst_mid_no_done", 64'({bus.done, bus.WVALID}), 64'd0);
        end
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            chk("post_rst_idle", 64'({bus.done, bus.WVALID, bus.cmd_ready}), 64'd1);
        end

        // Recovery after reset
        q_aw.push_back({16'h000C, 8'd0, 3'd2});
        q_w.push_back({32'h0000_0ABC, 1'b1});
        q_done.push_back(2'b00);
        issue(1'b1, 16'h000C, 8'd0, 3'd2, 32'hABC);
        wait_done("wr_recover", 50);

        repeat (5) @(negedge ACLK);
        chk("aw_leftover", 64'(q_aw.size()), 64'd0);
        chk("ar_leftover", 64'(q_ar.size()), 64'd0);
        chk("w_leftover", 64'(q_w.size()), 64'd0);
        chk("done_leftover", 64'(q_done.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
